// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester arbiter with one outstanding transaction to the mmu port.
// Optional BUSY watchdog compiled in with MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req_i,
  input  logic [31:0] r0_addr_i,
  input  logic        r0_we_i,
  input  logic [3:0]  r0_be_i,
  input  logic [31:0] r0_wdata_i,
  output logic        r0_gnt_o,
  output logic        r0_rvalid_o,
  output logic        r0_err_o,
  output logic [31:0] r0_rdata_o,
  input  logic        r1_req_i,
  input  logic [31:0] r1_addr_i,
  input  logic        r1_we_i,
  input  logic [3:0]  r1_be_i,
  input  logic [31:0] r1_wdata_i,
  output logic        r1_gnt_o,
  output logic        r1_rvalid_o,
  output logic        r1_err_o,
  output logic [31:0] r1_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic        owner_q, last_q, pick, start, done, busy, tmo, rsp_err;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES out of range");
  end
  // Outputs are gated by rst so everything reads 0 in the reset cycle itself.
  assign busy  = rst && state_q == BUSY;
  assign start = rst && state_q == IDLE && (r0_req_i || r1_req_i);
  assign pick  = (r0_req_i && r1_req_i) ? !last_q : r1_req_i;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign tmo = busy && !mem_rvalid_i && cnt_q == 16'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  assign done    = busy && (mem_rvalid_i || tmo);
  assign state_d = start ? BUSY : done ? IDLE : state_q;
  assign rsp_err = mem_rvalid_i ? mem_err_i : 1'b1;
  assign r0_gnt_o    = start && !pick;
  assign r1_gnt_o    = start && pick;
  assign r0_rvalid_o = done && !owner_q;
  assign r1_rvalid_o = done && owner_q;
  assign r0_err_o    = r0_rvalid_o && rsp_err;
  assign r1_err_o    = r1_rvalid_o && rsp_err;
  assign r0_rdata_o  = (r0_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
  assign r1_rdata_o  = (r1_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
  assign mem_req_o   = busy && !tmo;
  assign mem_addr_o  = mem_req_o ? addr_q : '0;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_be_o    = mem_req_o ? be_q : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start) begin
        owner_q <= pick;
        last_q  <= pick;
        addr_q  <= pick ? r1_addr_i : r0_addr_i;
        we_q    <= pick ? r1_we_i : r0_we_i;
        be_q    <= pick ? r1_be_i : r0_be_i;
        wdata_q <= pick ? r1_wdata_i : r0_wdata_i;
      end
`ifdef MEM_ARBITER_TIMEOUT_EN
      if (start) cnt_q <= '0;
      else if (busy) cnt_q <= cnt_q + 16'd1;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int T = 8;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic [3:0]  r0_be = 0, r1_be = 0;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 0, mem_err = 0;
  logic [31:0] mem_rdata = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_we_i(r0_we), .r0_be_i(r0_be), .r0_wdata_i(r0_wdata),
    .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid), .r0_err_o(r0_err), .r0_rdata_o(r0_rdata),
    .r1_req_i(r1_req), .r1_addr_i(r1_addr), .r1_we_i(r1_we), .r1_be_i(r1_be), .r1_wdata_i(r1_wdata),
    .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid), .r1_err_o(r1_err), .r1_rdata_o(r1_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err), .mem_rdata_i(mem_rdata)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // Transaction-level model: one open transaction record, who was granted last, BUSY age.
  typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; bit who;} txn_t;
  txn_t cur;
  bit   m_busy = 0, m_last = 1;
  int   m_age = 0;
  always @(negedge clk) begin
    logic        eg[2], ev[2], ee[2], emr, ewe;
    logic [31:0] ed[2], ea, ewd;
    logic [3:0]  ebe;
    bit          w;
    eg = '{0, 0}; ev = '{0, 0}; ee = '{0, 0}; ed = '{0, 0};
    emr = 0; ea = 0; ewe = 0; ebe = 0; ewd = 0;
    if (!rst) begin
      m_busy = 0; m_last = 1; m_age = 0;
    end else if (!m_busy) begin
      if (r0_req || r1_req) begin
        w = (r0_req && r1_req) ? !m_last : r1_req;
        eg[w] = 1;
        cur = w ? '{r1_addr, r1_we, r1_be, r1_wdata, 1'b1} : '{r0_addr, r0_we, r0_be, r0_wdata, 1'b0};
        m_busy = 1; m_last = w; m_age = 0;
      end
    end else begin
      m_age++;
      emr = 1; ea = cur.addr; ewe = cur.we; ebe = cur.be; ewd = cur.wdata;
      if (mem_rvalid) begin
        ev[cur.who] = 1; ee[cur.who] = mem_err; ed[cur.who] = mem_rdata; m_busy = 0;
      end else if (TMO && m_age == T) begin
        emr = 0; ea = 0; ewe = 0; ebe = 0; ewd = 0;
        ev[cur.who] = 1; ee[cur.who] = 1; m_busy = 0;
      end
    end
    chk("m_r0_gnt", 32'(r0_gnt), 32'(eg[0]));       chk("m_r1_gnt", 32'(r1_gnt), 32'(eg[1]));
    chk("m_r0_rvalid", 32'(r0_rvalid), 32'(ev[0])); chk("m_r1_rvalid", 32'(r1_rvalid), 32'(ev[1]));
    chk("m_r0_err", 32'(r0_err), 32'(ee[0]));       chk("m_r1_err", 32'(r1_err), 32'(ee[1]));
    chk("m_r0_rdata", r0_rdata, ed[0]);             chk("m_r1_rdata", r1_rdata, ed[1]);
    chk("m_mem_req", 32'(mem_req), 32'(emr));       chk("m_mem_addr", mem_addr, ea);
    chk("m_mem_we", 32'(mem_we), 32'(ewe));         chk("m_mem_be", 32'(mem_be), 32'(ebe));
    chk("m_mem_wdata", mem_wdata, ewd);
  end
  task automatic nxt();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    nxt(); rst = 0; nxt(); nxt(); rst = 1;
  endtask
  initial begin
    logic g0, g1;
    do_reset();
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0); chk("rst_r0_rvalid", 32'(r0_rvalid), 0);
    // single read by r0, response on the third BUSY cycle
    nxt(); r0_req = 1; r0_addr = 32'h2005;
    @(negedge clk); chk("rd_r0_gnt", 32'(r0_gnt), 1); chk("rd_memreq_g", 32'(mem_req), 0);
    nxt(); r0_req = 0;
    @(negedge clk); chk("rd_r0_gnt_b", 32'(r0_gnt), 0); chk("rd_memreq1", 32'(mem_req), 1); chk("rd_addr", mem_addr, 32'h2005);
    nxt(); @(negedge clk); chk("rd_memreq2", 32'(mem_req), 1);
    nxt(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("rd_memreq3", 32'(mem_req), 1); chk("rd_r0_rvalid", 32'(r0_rvalid), 1);
    chk("rd_r0_rdata", r0_rdata, 32'hDEADBEEF); chk("rd_r1_rvalid", 32'(r1_rvalid), 0); chk("rd_r1_rdata", r1_rdata, 0);
    nxt(); mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk); chk("rd_memreq_end", 32'(mem_req), 0);
    // both held: alternating grants starting with r0 after reset
    do_reset();
    nxt(); r0_req = 1; r1_req = 1; r0_addr = 32'h100; r1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin nxt(); mem_rvalid = 0; end
      @(negedge clk);
      chk("rr_r0_gnt", 32'(r0_gnt), 32'(i % 2 == 0)); chk("rr_r1_gnt", 32'(r1_gnt), 32'(i % 2 == 1));
      nxt(); mem_rvalid = 1;
      @(negedge clk); chk("rr_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
    end
    nxt(); mem_rvalid = 0; r0_req = 0; r1_req = 0;
    // r1 write with error response
    nxt(); r1_req = 1; r1_we = 1; r1_addr = 32'h1000; r1_wdata = 32'h12345678; r1_be = 4'hF;
    @(negedge clk); chk("wr_r1_gnt", 32'(r1_gnt), 1);
    nxt(); r1_req = 0;
    @(negedge clk); chk("wr_we", 32'(mem_we), 1); chk("wr_wdata", mem_wdata, 32'h12345678); chk("wr_be", 32'(mem_be), 32'hF);
    nxt(); mem_rvalid = 1; mem_err = 1;
    @(negedge clk); chk("wr_r1_rvalid", 32'(r1_rvalid), 1); chk("wr_r1_err", 32'(r1_err), 1); chk("wr_r0_rvalid", 32'(r0_rvalid), 0);
    nxt(); mem_rvalid = 0; mem_err = 0; r1_we = 0;
    // reset on the second BUSY cycle, then a late response
    nxt(); r0_req = 1;
    nxt(); r0_req = 0;
    nxt(); rst = 0;
    @(negedge clk); chk("mr_memreq", 32'(mem_req), 0);
    nxt(); rst = 1;
    @(negedge clk); chk("mr_memreq2", 32'(mem_req), 0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h55;
    @(negedge clk); chk("mr_r0_rvalid", 32'(r0_rvalid), 0); chk("mr_r1_rvalid", 32'(r1_rvalid), 0);
    nxt(); mem_rvalid = 0; mem_rdata = 0;
    // r0 waits while r1 is in flight
    nxt(); r1_req = 1;
    @(negedge clk); chk("wt_r1_gnt", 32'(r1_gnt), 1);
    nxt(); r1_req = 0; r0_req = 1;
    @(negedge clk); chk("wt_r0_gnt1", 32'(r0_gnt), 0);
    nxt(); @(negedge clk); chk("wt_r0_gnt2", 32'(r0_gnt), 0);
    nxt(); mem_rvalid = 1;
    @(negedge clk); chk("wt_r1_rvalid", 32'(r1_rvalid), 1); chk("wt_r0_gnt3", 32'(r0_gnt), 0);
    nxt(); mem_rvalid = 0;
    @(negedge clk); chk("wt_r0_gnt4", 32'(r0_gnt), 1);
    nxt(); r0_req = 0; mem_rvalid = 1;
    nxt(); mem_rvalid = 0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    nxt(); r0_req = 1;
    @(negedge clk); chk("to_r0_gnt", 32'(r0_gnt), 1);
    for (int k = 1; k <= T; k++) begin
      nxt(); r0_req = 0;
      @(negedge clk); chk("to_r0_rvalid", 32'(r0_rvalid), 32'(k == T));
    end
    chk("to_r0_err", 32'(r0_err), 1); chk("to_r0_rdata", r0_rdata, 0); chk("to_memreq", 32'(mem_req), 0);
    nxt(); r1_req = 1;
    @(negedge clk); chk("to_r1_gnt", 32'(r1_gnt), 1);
    nxt(); r1_req = 0; mem_rvalid = 1;
    nxt(); mem_rvalid = 0;
`endif
    // randomized traffic; requesters hold until granted
    g0 = 0; g1 = 0;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst = ($urandom % 97) != 0;
      if (r0_req && g0) r0_req = 0;
      else if (!r0_req && $urandom % 3 == 0) begin
        r0_req = 1; r0_addr = $urandom; r0_we = 1'($urandom); r0_be = 4'($urandom); r0_wdata = $urandom;
      end
      if (r1_req && g1) r1_req = 0;
      else if (!r1_req && $urandom % 3 == 0) begin
        r1_req = 1; r1_addr = $urandom; r1_we = 1'($urandom); r1_be = 4'($urandom); r1_wdata = $urandom;
      end
      mem_rvalid = ($urandom % 4) == 0; mem_err = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      g0 = r0_gnt; g1 = r1_gnt;
    end
    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: BUSY cycles without downstream rvalid before forced error (range 2..65535).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset; synchronous and active-low.
REQ-004 SHALL have r0_req_i, r1_req_i  input  1 each  requester 0 (instr fetch) / requester 1 (vproc data) request; held high until gnt.
REQ-005 SHALL have rN_addr_i  input  32, rN_we_i  input  1, rN_be_i  input  4, rN_wdata_i  input  32  per-requester transaction fields.
REQ-006 SHALL have rN_gnt_o  output  1  per-requester grant pulse.
REQ-007 SHALL have rN_rvalid_o  output  1, rN_err_o  output  1, rN_rdata_o  output  32  per-requester response.
REQ-008 SHALL have mem_req_o  output  1, mem_addr_o  output  32, mem_we_o  output  1, mem_be_o  output  4, mem_wdata_o  output  32  to the mmu vproc_mem port.
REQ-009 SHALL have mem_rvalid_i  input  1, mem_err_i  input  1, mem_rdata_i  input  32  mmu response.

Function
REQ-010 SHALL implement states IDLE and BUSY; at most one outstanding downstream transaction.
REQ-011 In IDLE with exactly one rN_req_i high, SHALL assert that rN_gnt_o combinationally that cycle, latch its addr/we/be/wdata, and enter BUSY next cycle.
REQ-012 In IDLE with both requests high, SHALL grant the requester not granted most recently (round-robin); after reset requester 0 wins first.
REQ-013 rN_gnt_o SHALL be high for exactly one cycle per transaction and never in BUSY.
REQ-014 In BUSY, mem_req_o SHALL be high and mem_addr/we/be/wdata_o SHALL equal the latched values, stable until the response cycle.
REQ-015 In IDLE, mem_req_o SHALL be low and all mem_* data outputs SHALL be 0.
REQ-016 The downstream SHALL return exactly one mem_rvalid_i pulse per request, reads and writes alike.
REQ-017 On mem_rvalid_i high in BUSY, SHALL drive the owner's rN_rvalid_o=1, rN_err_o=mem_err_i, rN_rdata_o=mem_rdata_i combinationally in that cycle, then return to IDLE.
REQ-018 Non-owner rvalid/err/rdata SHALL stay 0; rdata_o SHALL be 0 whenever its rvalid_o is 0.
REQ-019 mem_rvalid_i in IDLE SHALL be ignored.
REQ-020 Minimum grant-to-grant spacing SHALL be: grant cycle, >=1 BUSY cycle, 1 IDLE cycle.
REQ-021 A request arriving while BUSY SHALL wait; no request is dropped.

Reset
REQ-022 While rst=0 at a clock edge: state IDLE, round-robin pointer favouring requester 0, latched fields 0, timeout counter 0.
REQ-023 All outputs SHALL be 0 during and immediately after reset.
REQ-024 Reset mid-BUSY SHALL abandon the transaction: mem_req_o low next cycle, no rvalid to the owner.

Configuration
REQ-025 Macro MEM_ARBITER_TIMEOUT_EN SHALL compile in a BUSY-cycle counter, cleared on BUSY entry.
REQ-026 With MEM_ARBITER_TIMEOUT_EN: if the counter reaches TIMEOUT_CYCLES without mem_rvalid_i, that cycle SHALL give the owner rvalid=1, err=1, rdata=0, drop mem_req_o, and return to IDLE; mem_rvalid_i in the same cycle takes precedence.
REQ-027 Without MEM_ARBITER_TIMEOUT_EN: no counter logic; BUSY persists until mem_rvalid_i.

Verification
REQ-028 After reset, r0 read addr 0x2005 alone, mmu rvalid 3 cycles later with rdata 0xDEADBEEF -> r0_gnt 1 cycle, mem_req high 3 cycles, r0_rvalid with rdata 0xDEADBEEF, r1 outputs 0.
REQ-029 r0 and r1 requests together and held for 4 transactions -> grants r0, r1, r0, r1; each mem_addr matches its owner.
REQ-030 r1 write 0x1000 data 0x12345678 be 0xF, mmu rvalid err=1 -> r1_rvalid=1, r1_err=1.
REQ-031 rst=0 on 2nd BUSY cycle, then late mmu rvalid -> mem_req low next cycle, no rvalid to either requester.
REQ-032 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, mmu silent -> owner rvalid=1, err=1, rdata=0 on 8th BUSY cycle; next request granted normally.
REQ-033 r0 held high while BUSY on r1 -> r0_gnt only in the IDLE cycle after r1_rvalid.
